karatsuba_mul_iter: RTL and testbench

KARATSUBA_MUL_ITER -- requirements
Module: karatsuba_mul_iter

---
 rtl/kmul_pkg.sv | 25 ++
 rtl/karatsuba_mul_base.sv | 20 ++
 rtl/karatsuba_mul_iter.sv | 133 +++++++++++++
 tb/tb_karatsuba_mul_iter.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/kmul_pkg.sv
// kmul_pkg: shared FSM state encoding and width helpers for the iterative Karatsuba multiplier.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package kmul_pkg;

    typedef enum logic [2:0] {
        IDLE,
        MUL_LO,
        MUL_HI,
        MUL_MID,
        COMBINE,
        HOLD
    } kmul_state_t;

    // Width of one sub-product from the shared (HALF+1)x(HALF+1) multiplier.
    function automatic int kmul_prod_w(input int half);
        return 2 * half + 2;
    endfunction

    // Width of the middle term A0*B1 + A1*B0, which is at most 2*(2^HALF-1)^2.
    function automatic int kmul_mid_w(input int half);
        return 2 * half + 1;
    endfunction

endpackage

// File: rtl/karatsuba_mul_base.sv
// karatsuba_mul_base: combinational unsigned (HALF+1)x(HALF+1) multiplier, full-width product.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; the owner muxes operands and samples p.
// Ports: x, y = HALF+1-bit operands; p = 2*HALF+2-bit exact product.
module karatsuba_mul_base
    import kmul_pkg::*;
#(
    parameter int HALF = 128
) (
    input  logic [HALF:0]                  x,
    input  logic [HALF:0]                  y,
    output logic [kmul_prod_w(HALF)-1:0]   p
);

    localparam int PW = kmul_prod_w(HALF);

    // Operands widened first so the product is formed at full width.
    assign p = PW'(x) * PW'(y);

endmodule

// File: rtl/karatsuba_mul_iter.sv
// karatsuba_mul_iter: iterative one-level Karatsuba multiplier, c = a*b (unsigned, exact, 2*WIDTH bits).
// Latency: out_valid rises 4 clock edges after the accept edge; one pair in flight, 6-cycle issue interval.
// Backpressure: product held in HOLD until out_ready; in_ready low whenever busy, no input queuing.
// Ports: clk, rst_n (async, active-low); in_valid/in_ready with operands a, b;
//        out_valid/out_ready with product c; busy is high in every state except IDLE.
module karatsuba_mul_iter
    import kmul_pkg::*;
#(
    parameter int WIDTH = 256   // even, >= 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   c,
    output logic                 busy
);

    localparam int HALF = WIDTH / 2;
    localparam int PW   = kmul_prod_w(HALF);
    localparam int MW   = kmul_mid_w(HALF);
    localparam int OW   = 2 * WIDTH;
    localparam int CW   = 2 * WIDTH + 2;

    kmul_state_t state_q, state_d;

    logic [WIDTH-1:0]  a_q, b_q;
    logic [2*HALF-1:0] p0_q, p2_q;
    logic [PW-1:0]     p1_q;
    logic [OW-1:0]     c_q;

    logic              accept;
    logic [HALF:0]     sum_a, sum_b;
    logic [HALF:0]     mul_x, mul_y;
    logic [PW-1:0]     mul_p;
    logic [MW-1:0]     mid;
    logic [OW-1:0]     c_next;

    // Digit sums carry into bit HALF; that carry is why the shared multiplier is HALF+1 wide.
    assign sum_a = {1'b0, a_q[HALF-1:0]} + {1'b0, a_q[WIDTH-1:HALF]};
    assign sum_b = {1'b0, b_q[HALF-1:0]} + {1'b0, b_q[WIDTH-1:HALF]};

    // Operand mux: the single multiplier serves P0, P2 and P1 in successive states.
    always_comb begin
        mul_x = '0;
        mul_y = '0;
        case (state_q)
            MUL_LO: begin
                mul_x = {1'b0, a_q[HALF-1:0]};
                mul_y = {1'b0, b_q[HALF-1:0]};
            end
            MUL_HI: begin
                mul_x = {1'b0, a_q[WIDTH-1:HALF]};
                mul_y = {1'b0, b_q[WIDTH-1:HALF]};
            end
            MUL_MID: begin
                mul_x = sum_a;
                mul_y = sum_b;
            end
            default: ;
        endcase
    end

    karatsuba_mul_base #(
        .HALF (HALF)
    ) u_mul (
        .x (mul_x),
        .y (mul_y),
        .p (mul_p)
    );

    // P1 >= P0 + P2 always, so the subtraction never underflows; the result equals
    // A0*B1 + A1*B0 and fits MW bits, so dropping the MSB loses nothing.
    assign mid = MW'(p1_q - PW'(p0_q) - PW'(p2_q));

    // Sum formed at CW bits; the true product fits OW bits, so the top two bits are zero.
    assign c_next = OW'(CW'(p0_q) + (CW'(mid) << HALF) + (CW'(p2_q) << WIDTH));

    assign accept = in_valid & in_ready;

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) state_d = MUL_LO;
            end
            MUL_LO:  state_d = MUL_HI;
            MUL_HI:  state_d = MUL_MID;
            MUL_MID: state_d = COMBINE;
            COMBINE: state_d = HOLD;
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            p0_q    <= '0;
            p1_q    <= '0;
            p2_q    <= '0;
            c_q     <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                a_q <= a;
                b_q <= b;
            end
            if (state_q == MUL_LO)  p0_q <= mul_p[2*HALF-1:0];
            if (state_q == MUL_HI)  p2_q <= mul_p[2*HALF-1:0];
            if (state_q == MUL_MID) p1_q <= mul_p;
            if (state_q == COMBINE) c_q  <= c_next;
        end
    end

    // c keeps the last product while out_valid is low.
    assign c = c_q;

endmodule

// File: tb/tb_karatsuba_mul_iter.sv
// tb_karatsuba_mul_iter: directed checks of the iterative Karatsuba multiplier at WIDTH=256 and WIDTH=32.
// Latency: n/a (testbench).
// Backpressure: exercises HOLD stalls and back-to-back issue.
module tb_karatsuba_mul_iter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic rst_n;

    logic         in_valid_l, in_ready_l, out_valid_l, out_ready_l, busy_l;
    logic [255:0] a_l, b_l;
    logic [511:0] c_l;

    logic         in_valid_s, in_ready_s, out_valid_s, out_ready_s, busy_s;
    logic [31:0]  a_s, b_s;
    logic [63:0]  c_s;

    karatsuba_mul_iter #(.WIDTH(256)) dut_l (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid_l),
        .in_ready  (in_ready_l),
        .a         (a_l),
        .b         (b_l),
        .out_valid (out_valid_l),
        .out_ready (out_ready_l),
        .c         (c_l),
        .busy      (busy_l)
    );

    karatsuba_mul_iter #(.WIDTH(32)) dut_s (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid_s),
        .in_ready  (in_ready_s),
        .a         (a_s),
        .b         (b_s),
        .out_valid (out_valid_s),
        .out_ready (out_ready_s),
        .c         (c_s),
        .busy      (busy_s)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // s=1 selects the 32-bit instance, s=0 the 256-bit one.
    task automatic drive(input bit s, input logic v, input logic [255:0] av,
                         input logic [255:0] bv, input logic ordy);
        if (s) begin
            in_valid_s = v; a_s = av[31:0]; b_s = bv[31:0]; out_ready_s = ordy;
        end else begin
            in_valid_l = v; a_l = av; b_l = bv; out_ready_l = ordy;
        end
    endtask

    function automatic logic rdy(input bit s);
        return s ? in_ready_s : in_ready_l;
    endfunction

    function automatic logic vld(input bit s);
        return s ? out_valid_s : out_valid_l;
    endfunction

    function automatic logic [511:0] cval(input bit s);
        return s ? {448'b0, c_s} : c_l;
    endfunction

    function automatic logic [255:0] rnd(input bit s);
        logic [255:0] r;
        for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom;
        if ($urandom_range(0, 7) == 0) r = '1;
        if (s) r[255:32] = '0;
        return r;
    endfunction

    // Called 1 time unit after a rising edge with in_valid already high; returns
    // 1 time unit after the accept edge, with t = cycle count of that edge.
    task automatic wait_accept(input bit s, output int t);
        int n;
        n = 0;
        while (!rdy(s) && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk(s ? "s_in_ready_wait" : "l_in_ready_wait", rdy(s), 1'b1);
        @(posedge clk); #1;
        t = cyc;
    endtask

    task automatic wait_out(input bit s, output int e);
        e = 0;
        while (!vld(s) && e < 20) begin
            @(posedge clk); #1;
            e++;
        end
    endtask

    task automatic run(input bit s, input logic [255:0] av, input logic [255:0] bv,
                       input logic [511:0] exp, input string tag);
        int t, e;
        drive(s, 1'b1, av, bv, 1'b1);
        wait_accept(s, t);
        // Operands change right after the accept edge; the product must not follow.
        drive(s, 1'b0, ~av, bv ^ 256'h5a5a_a5a5, 1'b1);
        wait_out(s, e);
        chk({tag, "_latency"}, e, 4);
        chk({tag, "_c"}, cval(s), exp);
        @(posedge clk); #1;
        chk({tag, "_drop_valid"}, vld(s), 1'b0);
        chk({tag, "_c_held"}, cval(s), exp);
    endtask

    task automatic bb(input bit s, input int n, input string tag);
        logic [255:0] av, bv;
        logic [511:0] exp;
        int t, tp, e;
        av = rnd(s);
        bv = rnd(s);
        drive(s, 1'b1, av, bv, 1'b1);
        tp = 0;
        for (int i = 0; i < n; i++) begin
            wait_accept(s, t);
            exp = 512'(av) * 512'(bv);
            av = rnd(s);
            bv = rnd(s);
            drive(s, 1'b1, av, bv, 1'b1);
            if (i > 0) chk({tag, "_interval"}, t - tp, 6);
            tp = t;
            wait_out(s, e);
            chk({tag, "_c"}, cval(s), exp);
        end
        drive(s, 1'b0, '0, '0, 1'b1);
        @(posedge clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time %0t exceeded limit 2000000", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int t, e;
        bit seen;

        rst_n = 1'b0;
        drive(0, 1'b0, '0, '0, 1'b0);
        drive(1, 1'b0, '0, '0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_c_l", c_l, '0);
        chk("rst_out_valid_l", out_valid_l, 1'b0);
        chk("rst_busy_l", busy_l, 1'b0);
        chk("rst_c_s", {448'b0, c_s}, '0);

        // a=0 presented before release; the first edge with rst_n high must accept it.
        drive(0, 1'b1, '0, 256'h1234_5678_9abc_def0_0fed_cba9_8765_4321, 1'b1);
        rst_n = 1'b1;
        chk("rst_in_ready_l", in_ready_l, 1'b1);
        @(posedge clk); #1;
        chk("first_accept_busy", busy_l, 1'b1);
        drive(0, 1'b0, '0, '0, 1'b1);
        wait_out(0, e);
        chk("zero_latency", e, 4);
        chk("zero_c", c_l, '0);
        @(posedge clk); #1;

        // 256-bit directed products.
        run(0, '1, '1, {{255{1'b1}}, 1'b0, {255{1'b0}}, 1'b1}, "ones256");
        run(0, 256'h1 << 128, (256'h1 << 128) + 256'd3,
            (512'h1 << 256) + (512'h3 << 128), "split256");
        run(0, (256'h1 << 128) - 256'd1, '1,
            (512'h1 << 384) - (512'h1 << 256) - (512'h1 << 128) + 512'd1, "lowones256");

        // 32-bit directed products.
        run(1, 256'd3, 256'd5, 512'd15, "small32");
        run(1, 256'hFFFF_FFFF, 256'hFFFF_FFFF, 512'hFFFF_FFFE_0000_0001, "ones32");

        // in_valid toggling with fresh operands while busy.
        drive(0, 1'b1, 256'd1234567, 256'd7654321, 1'b1);
        wait_accept(0, t);
        for (int i = 0; i < 4; i++) begin
            drive(0, (i % 2) == 0, 256'(i + 99), 256'(i + 7), 1'b1);
            chk("toggle_in_ready", in_ready_l, 1'b0);
            @(posedge clk); #1;
        end
        chk("toggle_valid", out_valid_l, 1'b1);
        chk("toggle_c", c_l, 512'd9449772114007);
        drive(0, 1'b1, 256'd2, 256'd2, 1'b1);
        @(posedge clk); #1;
        chk("toggle_hold_no_accept", busy_l, 1'b0);
        wait_accept(0, t);
        drive(0, 1'b0, '0, '0, 1'b1);
        wait_out(0, e);
        chk("toggle_next_c", c_l, 512'd4);
        @(posedge clk); #1;

        // Reset during MUL_MID discards the product.
        drive(0, 1'b1, 256'd11, 256'd13, 1'b1);
        wait_accept(0, t);
        drive(0, 1'b0, '0, '0, 1'b1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("midrst_busy_before", busy_l, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("midrst_c", c_l, '0);
        chk("midrst_busy", busy_l, 1'b0);
        chk("midrst_out_valid", out_valid_l, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            seen = seen | out_valid_l;
            @(posedge clk); #1;
        end
        chk("midrst_no_stale_valid", seen, 1'b0);
        run(0, 256'd3, 256'd5, 512'd15, "post_rst");

        // Back-pressure stall in HOLD at WIDTH=32.
        drive(1, 1'b1, 256'h0001_0000, 256'hFFFF_FFFF, 1'b0);
        wait_accept(1, t);
        drive(1, 1'b0, '0, '0, 1'b0);
        wait_out(1, e);
        chk("stall_latency", e, 4);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("stall_c", {448'b0, c_s}, 512'hFFFF_FFFF_0000);
            chk("stall_in_ready", in_ready_s, 1'b0);
            chk("stall_out_valid", out_valid_s, 1'b1);
        end
        drive(1, 1'b0, '0, '0, 1'b1);
        @(posedge clk); #1;
        chk("stall_release_valid", out_valid_s, 1'b0);
        chk("stall_release_ready", in_ready_s, 1'b1);
        @(posedge clk); #1;
        chk("stall_single_handshake", out_valid_s, 1'b0);
        chk("stall_c_kept", {448'b0, c_s}, 512'hFFFF_FFFF_0000);

        // Back-to-back random traffic against a plain multiply.
        bb(1, 1000, "b2b32");
        bb(0, 1000, "b2b256");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
